// File: rtl/idct_1d_10to8_pkg.sv
// Shared IDCT types, widths and Q13 cosine constants.
// cmul() forms the exact constant-times-coefficient product at accumulator width.
package idct_1d_10to8_pkg;

   localparam int IN_W  = 10;
   localparam int OUT_W = 8;
   localparam int CW    = 13;
   localparam int ACC_W = 28;
   localparam int SHIFT = 14;

   localparam logic [CW-1:0] C_A = 13'd5793;
   localparam logic [CW-1:0] C_B = 13'd7568;
   localparam logic [CW-1:0] C_C = 13'd3135;
   localparam logic [CW-1:0] C_D = 13'd8035;
   localparam logic [CW-1:0] C_E = 13'd6811;
   localparam logic [CW-1:0] C_F = 13'd4551;
   localparam logic [CW-1:0] C_G = 13'd1598;

   typedef logic signed [IN_W-1:0]  coef_t;
   typedef logic signed [OUT_W-1:0] samp_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   function automatic acc_t cmul(input logic [CW-1:0] c, input coef_t y);
      return acc_t'($signed({1'b0, c})) * acc_t'(y);
   endfunction

endpackage

// File: rtl/idct_1d_10to8_if.sv
// Coefficient-in / sample-out bundle of the 1-D IDCT; master drives coefficients.
// No ready signal: the consumer must accept every valid vector.
interface idct_1d_10to8_if;
   import idct_1d_10to8_pkg::*;

   logic       enable;
   coef_t      y0, y1, y2, y3, y4, y5, y6, y7;
   samp_t      x0, x1, x2, x3, x4, x5, x6, x7;
   logic       valid;
   logic [7:0] sat;

   modport master (
      output enable, y0, y1, y2, y3, y4, y5, y6, y7,
      input  x0, x1, x2, x3, x4, x5, x6, x7, valid, sat
   );

   modport slave (
      input  enable, y0, y1, y2, y3, y4, y5, y6, y7,
      output x0, x1, x2, x3, x4, x5, x6, x7, valid, sat
   );

endinterface

// File: rtl/idct_1d_10to8_round_sat.sv
// Combinational round-half-up, arithmetic shift by SHIFT, clip to samp_t range.
// sat is raised whenever the shifted value had to be clipped.
module idct_round_sat
   import idct_1d_10to8_pkg::*;
(
   input  acc_t  din,
   output samp_t dout,
   output logic  sat
);
   localparam acc_t RND  = acc_t'(1) <<< (SHIFT - 1);
   localparam acc_t SMAX = acc_t'((1 <<< (OUT_W - 1)) - 1);
   localparam acc_t SMIN = -SMAX - acc_t'(1);

   acc_t sh;

   always_comb begin
      sh   = (din + RND) >>> SHIFT;
      dout = samp_t'(sh);
      sat  = 1'b0;
      if (sh > SMAX) begin
         dout = samp_t'(SMAX);
         sat  = 1'b1;
      end else if (sh < SMIN) begin
         dout = samp_t'(SMIN);
         sat  = 1'b1;
      end
   end
endmodule

// File: rtl/idct_1d_10to8.sv
// 8-point 1-D IDCT, 10-bit signed coefficients to 8-bit saturated samples.
// Fixed 4-cycle latency, one vector per cycle, no backpressure.
module idct_1d_10to8
   import idct_1d_10to8_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   idct_1d_10to8_if.slave io
);
   logic [4:0] vld;
   coef_t      y_r   [8];
   acc_t       p_a0, p_a4, p_b2, p_c2, p_b6, p_c6;
   acc_t       p_odd [4][4];  // [y1,y3,y5,y7][D,E,F,G]
   acc_t       e_r   [4];
   acc_t       op_r  [8];
   acc_t       a_r   [4];
   acc_t       o_r   [4];
   acc_t       sum   [8];
   samp_t      rs_x  [8];
   logic [7:0] rs_sat;
   samp_t      x_r   [8];
   logic [7:0] sat_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < 8; i++) y_r[i] <= '0;
      end else begin
         vld <= {vld[3:0], io.enable};
         if (io.enable) begin
            y_r[0] <= io.y0; y_r[1] <= io.y1; y_r[2] <= io.y2; y_r[3] <= io.y3;
            y_r[4] <= io.y4; y_r[5] <= io.y5; y_r[6] <= io.y6; y_r[7] <= io.y7;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_a0 <= '0; p_a4 <= '0; p_b2 <= '0; p_c2 <= '0; p_b6 <= '0; p_c6 <= '0;
         for (int j = 0; j < 4; j++)
            for (int c = 0; c < 4; c++) p_odd[j][c] <= '0;
      end else if (vld[0]) begin
         p_a0 <= cmul(C_A, y_r[0]);
         p_a4 <= cmul(C_A, y_r[4]);
         p_b2 <= cmul(C_B, y_r[2]);
         p_c2 <= cmul(C_C, y_r[2]);
         p_b6 <= cmul(C_B, y_r[6]);
         p_c6 <= cmul(C_C, y_r[6]);
         for (int j = 0; j < 4; j++) begin
            p_odd[j][0] <= cmul(C_D, y_r[2*j+1]);
            p_odd[j][1] <= cmul(C_E, y_r[2*j+1]);
            p_odd[j][2] <= cmul(C_F, y_r[2*j+1]);
            p_odd[j][3] <= cmul(C_G, y_r[2*j+1]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) e_r[i]  <= '0;
         for (int i = 0; i < 8; i++) op_r[i] <= '0;
      end else if (vld[1]) begin
         e_r[0]  <= p_a0 + p_a4;
         e_r[1]  <= p_a0 - p_a4;
         e_r[2]  <= p_b2 + p_c6;
         e_r[3]  <= p_c2 - p_b6;
         op_r[0] <= p_odd[0][0] + p_odd[1][1];
         op_r[1] <= p_odd[2][2] + p_odd[3][3];
         op_r[2] <= p_odd[0][1] - p_odd[1][3];
         op_r[3] <= p_odd[2][0] + p_odd[3][2];
         op_r[4] <= p_odd[0][2] - p_odd[1][0];
         op_r[5] <= p_odd[2][3] + p_odd[3][1];
         op_r[6] <= p_odd[0][3] - p_odd[1][2];
         op_r[7] <= p_odd[2][1] - p_odd[3][0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            a_r[i] <= '0;
            o_r[i] <= '0;
         end
      end else if (vld[2]) begin
         a_r[0] <= e_r[0] + e_r[2];
         a_r[1] <= e_r[1] + e_r[3];
         a_r[2] <= e_r[1] - e_r[3];
         a_r[3] <= e_r[0] - e_r[2];
         o_r[0] <= op_r[0] + op_r[1];
         o_r[1] <= op_r[2] - op_r[3];
         o_r[2] <= op_r[4] + op_r[5];
         o_r[3] <= op_r[6] + op_r[7];
      end
   end

   // Output butterfly: lane n takes a+o, mirrored lane 7-n takes a-o.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         sum[n]     = a_r[n] + o_r[n];
         sum[7 - n] = a_r[n] - o_r[n];
      end
   end

   for (genvar n = 0; n < 8; n++) begin : g_rs
      idct_round_sat u_rs (
         .din  (sum[n]),
         .dout (rs_x[n]),
         .sat  (rs_sat[n])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) x_r[i] <= '0;
         sat_r <= '0;
      end else if (vld[3]) begin
         for (int i = 0; i < 8; i++) x_r[i] <= rs_x[i];
         sat_r <= rs_sat;
      end
   end

   assign io.x0    = x_r[0];
   assign io.x1    = x_r[1];
   assign io.x2    = x_r[2];
   assign io.x3    = x_r[3];
   assign io.x4    = x_r[4];
   assign io.x5    = x_r[5];
   assign io.x6    = x_r[6];
   assign io.x7    = x_r[7];
   assign io.sat   = sat_r;
   assign io.valid = vld[4];

endmodule

// File: tb/tb_idct_1d_10to8.sv
// Scoreboarded bench for idct_1d_10to8: directed spec vectors, gap streaming,
// random vectors against a cosine-matrix reference, and asynchronous reset mid-stream.
module tb_idct_1d_10to8;
   import idct_1d_10to8_pkg::*;

   typedef struct packed {
      int          due;
      logic [63:0] xv;
      logic [7:0]  sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q[$];
   exp_t e;
   logic [63:0] last_xv = '0;
   logic [7:0]  last_sat = '0;
   logic [63:0] act;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   idct_1d_10to8_if io ();

   idct_1d_10to8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   // Q13 basis value of coefficient k at sample n, folded from cos(m*pi/16).
   function automatic int cosq(input int k, input int n);
      int m, sgn, v;
      if (k == 0) return 5793;
      m   = (k * (2 * n + 1)) % 32;
      sgn = 1;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
         m   = 16 - m;
         sgn = -1;
      end
      case (m)
         1: v = 8035;
         2: v = 7568;
         3: v = 6811;
         4: v = 5793;
         5: v = 4551;
         6: v = 3135;
         7: v = 1598;
         default: v = 0;
      endcase
      return sgn * v;
   endfunction

   function automatic logic [71:0] ref_idct(input int yv[8]);
      logic [63:0] xv;
      logic [7:0]  s;
      int acc, r;
      xv = '0;
      s  = '0;
      for (int n = 0; n < 8; n++) begin
         acc = 0;
         for (int k = 0; k < 8; k++) acc += cosq(k, n) * yv[k];
         r = (acc + 8192) >>> 14;
         if (r > 127) begin r = 127; s[n] = 1'b1; end
         if (r < -128) begin r = -128; s[n] = 1'b1; end
         xv[8*n +: 8] = r[7:0];
      end
      return {s, xv};
   endfunction

   function automatic logic [63:0] pack_x(input int xs[8]);
      logic [63:0] v;
      int t;
      for (int n = 0; n < 8; n++) begin
         t = xs[n];
         v[8*n +: 8] = t[7:0];
      end
      return v;
   endfunction

   task automatic drive(input int yv[8], input logic [71:0] ex);
      @(negedge clk);
      io.enable = 1'b1;
      io.y0 = coef_t'(yv[0]); io.y1 = coef_t'(yv[1]); io.y2 = coef_t'(yv[2]); io.y3 = coef_t'(yv[3]);
      io.y4 = coef_t'(yv[4]); io.y5 = coef_t'(yv[5]); io.y6 = coef_t'(yv[6]); io.y7 = coef_t'(yv[7]);
      q.push_back('{due: cyc + 5, xv: ex[63:0], sat: ex[71:64]});
   endtask

   task automatic drive_ref(input int yv[8]);
      drive(yv, ref_idct(yv));
   endtask

   // Idle cycles carry garbage coefficients that must not be captured.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         io.enable = 1'b0;
         io.y0 = coef_t'($urandom); io.y1 = coef_t'($urandom); io.y2 = coef_t'($urandom);
         io.y3 = coef_t'($urandom); io.y4 = coef_t'($urandom); io.y5 = coef_t'($urandom);
         io.y6 = coef_t'($urandom); io.y7 = coef_t'($urandom);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         act = {io.x7, io.x6, io.x5, io.x4, io.x3, io.x2, io.x1, io.x0};
         if (io.valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_valid cyc=%0d x=%h sat=%h", cyc, act, io.sat);
            end else begin
               e = q.pop_front();
               if (e.due != cyc || act != e.xv || io.sat != e.sat) begin
                  errors++;
                  $display("FAIL vector cyc=%0d got x=%h sat=%h, expected cyc=%0d x=%h sat=%h",
                           cyc, act, io.sat, e.due, e.xv, e.sat);
               end
               last_xv  = e.xv;
               last_sat = e.sat;
            end
         end else begin
            if (q.size() != 0 && q[0].due <= cyc) begin
               checks++;
               errors++;
               $display("FAIL missing_valid cyc=%0d expected at cyc=%0d", cyc, q[0].due);
               void'(q.pop_front());
            end
            checks++;
            if (act != last_xv || io.sat != last_sat) begin
               errors++;
               $display("FAIL hold cyc=%0d got x=%h sat=%h, expected x=%h sat=%h",
                        cyc, act, io.sat, last_xv, last_sat);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      int yv[8];
      int xs[8];
      int mode;

      io.enable = 1'b0;
      io.y0 = '0; io.y1 = '0; io.y2 = '0; io.y3 = '0;
      io.y4 = '0; io.y5 = '0; io.y6 = '0; io.y7 = '0;

      #12;
      checks++;
      if (io.valid !== 1'b0 || {io.x7, io.x6, io.x5, io.x4, io.x3, io.x2, io.x1, io.x0} !== 64'd0
          || io.sat !== 8'd0) begin
         errors++;
         $display("FAIL reset_state valid=%b sat=%h, expected all zero", io.valid, io.sat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Directed vectors with literal expectations.
      yv = '{359, 0, 0, 0, 0, 0, 0, 0};
      xs = '{127, 127, 127, 127, 127, 127, 127, 127};
      drive(yv, {8'h00, pack_x(xs)});
      idle(6);
      yv = '{-362, 0, 0, 0, 0, 0, 0, 0};
      xs = '{-128, -128, -128, -128, -128, -128, -128, -128};
      drive(yv, {8'h00, pack_x(xs)});
      idle(6);
      yv = '{511, 0, 0, 0, 0, 0, 0, 0};
      xs = '{127, 127, 127, 127, 127, 127, 127, 127};
      drive(yv, {8'hFF, pack_x(xs)});
      idle(6);
      yv = '{0, 100, 0, 0, 0, 0, 0, 0};
      xs = '{49, 42, 28, 10, -10, -28, -42, -49};
      drive(yv, {8'h00, pack_x(xs)});
      idle(6);

      // Streaming 1,1,0,1.
      yv = '{359, 0, 0, 0, 0, 0, 0, 0};
      xs = '{127, 127, 127, 127, 127, 127, 127, 127};
      drive(yv, {8'h00, pack_x(xs)});
      yv = '{0, 100, 0, 0, 0, 0, 0, 0};
      xs = '{49, 42, 28, 10, -10, -28, -42, -49};
      drive(yv, {8'h00, pack_x(xs)});
      idle(1);
      yv = '{-362, 0, 0, 0, 0, 0, 0, 0};
      xs = '{-128, -128, -128, -128, -128, -128, -128, -128};
      drive(yv, {8'h00, pack_x(xs)});
      idle(6);

      // Random vectors against the reference, with random gaps.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            mode = int'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++)
               yv[k] = (mode == 1) ? int'($urandom_range(0, 1023)) - 512
                                   : int'($urandom_range(0, 200)) - 100;
            drive_ref(yv);
         end else begin
            idle(1);
         end
      end
      idle(6);

      // Reset with three vectors in flight.
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 8; k++) yv[k] = int'($urandom_range(0, 200)) - 100;
         drive_ref(yv);
      end
      idle(1);
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (io.valid !== 1'b1) begin
         errors++;
         $display("FAIL prereset_valid got %b, expected 1", io.valid);
      end
      q.delete();
      rst_n = 1'b0;
      #1;
      checks++;
      if (io.valid !== 1'b0 || {io.x7, io.x6, io.x5, io.x4, io.x3, io.x2, io.x1, io.x0} !== 64'd0
          || io.sat !== 8'd0) begin
         errors++;
         $display("FAIL async_reset valid=%b x=%h sat=%h, expected all zero", io.valid,
                  {io.x7, io.x6, io.x5, io.x4, io.x3, io.x2, io.x1, io.x0}, io.sat);
      end
      last_xv  = '0;
      last_sat = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);
      yv = '{0, 100, 0, 0, 0, 0, 0, 0};
      xs = '{49, 42, 28, 10, -10, -28, -42, -49};
      drive(yv, {8'h00, pack_x(xs)});
      idle(8);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending, expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/idct_1d_10to8.md
Name: idct_1d_10to8

Overview:
- 8-point 1-D inverse DCT. It is the decode-side counterpart of the forward 8→10 DCT row/column stage.
- Takes eight 10-bit signed coefficients per cycle and produces eight 8-bit signed spatial samples.
- Fully pipelined with one vector per cycle and no backpressure.
- Two instances plus a transpose buffer form the 2-D IDCT in the reconstruction path.

Parameters:
- IN_W, 10, coefficient width (signed)
- OUT_W, 8, sample width (signed, saturated)
- CW, 13, cosine constant width (unsigned, Q13)
- ACC_W, 28, internal signed accumulator width
- SHIFT, 14, final right shift (Q13 constant plus orthonormal 1/2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  input vector valid
- y0..y7  in  10 each  signed DCT coefficients, k=0..7
- x0..x7  out  8 each  signed reconstructed samples, n=0..7
- valid  out  1  output vector valid
- sat  out  8  per-lane saturation flag; bit n refers to xn

Behaviour:
- Reset: one clock `clk`; reset is asynchronous and active-low on `rst_n`.
  - Asserting rst_n clears all pipeline data and valid bits, x0..x7, and sat to 0, and valid to 0, immediately and without a clock.
  - In-flight vectors are discarded. After release, nothing stale emerges.
- Constants (Q13): A=5793, B=7568, C=3135, D=8035, E=6811, F=4551, G=1598.
- Register stages (a vector sampled at edge N produces outputs at edge N+4, i.e. a fixed 4-cycle latency):
  - S0 (edge N): register y0..y7 and enable.
  - S1 (N+1): register products. Each product is an unsigned constant times a signed coefficient, sign-extended to ACC_W. Exact, no truncation.
  - S2 (N+2): register partial sums.
    - Even: e0=Ay0+Ay4, e1=Ay0−Ay4, e2=By2+Cy6, e3=Cy2−By6.
    - Odd pairs: Dy1+Ey3, Fy5+Gy7, Ey1−Gy3, Dy5+Fy7, Fy1−Dy3, Gy5+Ey7, Gy1−Fy3, Ey5−Dy7.
  - S3 (N+3): register a0=e0+e2, a1=e1+e3, a2=e1−e3, a3=e0−e2.
    - o0=Dy1+Ey3+Fy5+Gy7
    - o1=Ey1−Gy3−Dy5−Fy7
    - o2=Fy1−Dy3+Gy5+Ey7
    - o3=Gy1−Fy3+Ey5−Dy7
  - S4 (N+4): butterfly, then round, shift and saturate, then register to x0..x7 and sat.
    - xn = rs(an+on) and x(7−n) = rs(an−on), for n=0..3.
    - rs(v) = saturate((v + 2^13) >>> 14) to [−128, 127]. This is round-half-up via arithmetic shift.
    - sat[n] is 1 when lane n clipped.
- valid: a 5-bit valid shift register tracks enable through S0..S4. valid equals the S4 valid bit.
- Data gating: each stage's data registers load only when that stage's incoming valid is 1 and hold otherwise. x0..x7 and sat therefore hold the last vector while valid=0.
- Throughput: back-to-back enable is accepted every cycle. Gaps are reproduced exactly at the output, delayed 4 cycles.
- Overflow: ACC_W=28 covers the worst case |4·8191·512|·2 without overflow. Saturation is the only lossy step besides rounding.
- Round trip: forward DCT followed by this block returns the input within ±1 LSB for all inputs in [−128, 127].

Decomposition:
- Shared package (dct_pkg):
  - constants A..G
  - IN_W / OUT_W / ACC_W / SHIFT
  - typedefs coef_t (signed [9:0]), samp_t (signed [7:0]), acc_t (signed [27:0])
  - The forward DCT is migrated to the same constants.
- One sub-module, idct_round_sat: combinational acc_t in → samp_t out plus a sat flag. It is instantiated 8 times in S4.

Test Plan:
- DC positive: y0=359, others 0, enable for 1 cycle → valid pulses 1 cycle at edge +4; all xn=127; sat=0x00.
- DC negative: y0=−362, others 0 → all xn=−128; sat=0x00.
- Saturation: y0=511, others 0 → raw 181 clipped; all xn=127; sat=0xFF.
- Odd basis: y1=100, others 0 → x0..x7 = 49, 42, 28, 10, −10, −28, −42, −49; sat=0.
- Streaming with gaps: enable pattern 1,1,0,1 with vectors from the DC positive, odd basis and DC negative scenarios → valid pattern 1,1,0,1 starting at edge +4; each output matches its vector; outputs hold through the gap. Also run 10k random samples in [−128, 127] through dct_1d_8to10 then this block: |x−x_in| ≤ 1.
- Reset mid-stream: 3 vectors in flight, pull rst_n low between edges → valid, x0..x7 and sat go to 0 asynchronously. After release, no valid is produced until a new enable, then exactly 4 cycles later.
